// File: rtl/lfsr_stream.sv
// Pseudo-random word source: W-bit LFSR with programmable taps, Fibonacci or
// Galois form, OUT_W bits per word, valid/ready output and lock-up detection.
module lfsr_stream #(
    parameter int            W        = 8,
    parameter int            OUT_W    = 1,
    parameter logic [W-1:0]  DEF_TAPS = 8'hB8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [W-1:0]     cfg_taps,
    input  logic             cfg_mode,
    input  logic             seed_valid,
    input  logic [W-1:0]     seed_data,
    output logic             seed_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [W-1:0]     state_q,
    output logic             lockup,
    output logic [31:0]      word_cnt
);

    // state | meaning
    // IDLE  | after reset, no word offered, config writable
    // RUN   | word on out_data, advances on accept
    // LOCK  | LFSR collapsed to zero, config writable, waits for a seed
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LOCK = 2'd2
    } fsm_t;

    fsm_t         fsm_q, fsm_d;
    logic [W-1:0] lfsr_q, lfsr_d;
    logic [W-1:0] taps_q, taps_d;
    logic         mode_q, mode_d;
    logic [31:0]  cnt_q, cnt_d;

    logic [W-1:0]     q_adv;
    logic [OUT_W-1:0] step_bits;

    // OUT_W chained steps from the registered state; bit i comes from step i.
    always_comb begin
        q_adv     = lfsr_q;
        step_bits = '0;
        for (int i = 0; i < OUT_W; i++) begin
            if (!mode_q) begin
                step_bits[i] = ^(q_adv & taps_q);
                q_adv        = {q_adv[W-2:0], step_bits[i]};
            end else begin
                step_bits[i] = q_adv[W-1];
                q_adv        = {q_adv[W-2:0], 1'b0} ^ (q_adv[W-1] ? taps_q : '0);
            end
        end
    end

    always_comb begin
        fsm_d  = fsm_q;
        lfsr_d = lfsr_q;
        taps_d = taps_q;
        mode_d = mode_q;
        cnt_d  = cnt_q;

        if (cfg_we && (fsm_q != ST_RUN)) begin
            taps_d = cfg_taps;
            mode_d = cfg_mode;
        end

        // A seed overrides any accept in the same cycle.
        if (seed_valid) begin
            lfsr_d = (seed_data == '0) ? W'(1) : seed_data;
            cnt_d  = '0;
            fsm_d  = ST_RUN;
        end else if ((fsm_q == ST_RUN) && out_ready) begin
            if (q_adv == '0) begin
                lfsr_d = '0;
                fsm_d  = ST_LOCK;
            end else begin
                lfsr_d = q_adv;
                if (cnt_q != 32'hFFFF_FFFF) begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q  <= ST_IDLE;
            lfsr_q <= W'(1);
            taps_q <= DEF_TAPS;
            mode_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            fsm_q  <= fsm_d;
            lfsr_q <= lfsr_d;
            taps_q <= taps_d;
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
        end
    end

    assign seed_ready = 1'b1;
    assign out_valid  = (fsm_q == ST_RUN);
    assign lockup     = (fsm_q == ST_LOCK);
    assign out_data   = step_bits;
    assign state_q    = lfsr_q;
    assign word_cnt   = cnt_q;

endmodule

// File: tb/tb_lfsr_stream.sv
// Directed bench for lfsr_stream: one instance with OUT_W=1, one with OUT_W=4,
// sharing clock, reset, config and seed inputs; out_ready is separate per instance.
module tb_lfsr_stream;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_we = 1'b0;
    logic [7:0] cfg_taps = 8'h00;
    logic       cfg_mode = 1'b0;
    logic       seed_valid = 1'b0;
    logic [7:0] seed_data = 8'h00;
    logic       out_ready1 = 1'b0;
    logic       out_ready4 = 1'b0;

    logic        seed_ready1, out_valid1, lockup1;
    logic [0:0]  out_data1;
    logic [7:0]  state1;
    logic [31:0] cnt1;
    logic        seed_ready4, out_valid4, lockup4;
    logic [3:0]  out_data4;
    logic [7:0]  state4;
    logic [31:0] cnt4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lfsr_stream #(.W(8), .OUT_W(1), .DEF_TAPS(8'hB8)) dut1 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_taps(cfg_taps), .cfg_mode(cfg_mode),
        .seed_valid(seed_valid), .seed_data(seed_data), .seed_ready(seed_ready1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .state_q(state1), .lockup(lockup1), .word_cnt(cnt1)
    );

    lfsr_stream #(.W(8), .OUT_W(4), .DEF_TAPS(8'hB8)) dut4 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_taps(cfg_taps), .cfg_mode(cfg_mode),
        .seed_valid(seed_valid), .seed_data(seed_data), .seed_ready(seed_ready4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
        .state_q(state4), .lockup(lockup4), .word_cnt(cnt4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic do_seed(input logic [7:0] s);
        seed_valid = 1'b1;
        seed_data  = s;
        tick();
        seed_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", out_valid1); end
        checks++; if (lockup1 !== 1'b0) begin errors++; $display("FAIL reset_lockup: got %0b expected 0", lockup1); end
        checks++; if (state1 !== 8'h01) begin errors++; $display("FAIL reset_state: got %0h expected 01", state1); end
        checks++; if (cnt1 !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", cnt1); end
        checks++; if (seed_ready1 !== 1'b1) begin errors++; $display("FAIL reset_seed_ready: got %0b expected 1", seed_ready1); end
        checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL reset_valid4: got %0b expected 0", out_valid4); end
    endtask

    task automatic test_fib_seq();
        logic [7:0] exp_s [4] = '{8'h01, 8'h02, 8'h04, 8'h08};
        logic       exp_d [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        int n;
        int first_ret;
        out_ready1 = 1'b1;
        do_seed(8'h01);
        checks++; if (out_valid1 !== 1'b1) begin errors++; $display("FAIL fib_valid: got %0b expected 1", out_valid1); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (state1 !== exp_s[i]) begin errors++; $display("FAIL fib_state[%0d]: got %0h expected %0h", i, state1, exp_s[i]); end
            checks++; if (out_data1[0] !== exp_d[i]) begin errors++; $display("FAIL fib_data[%0d]: got %0b expected %0b", i, out_data1[0], exp_d[i]); end
            tick();
        end
        checks++; if (state1 !== 8'h11) begin errors++; $display("FAIL fib_state[4]: got %0h expected 11", state1); end
        n = 4;
        first_ret = 0;
        while (n < 255) begin
            tick();
            n++;
            if (state1 == 8'h01 && first_ret == 0) first_ret = n;
        end
        checks++; if (first_ret !== 255) begin errors++; $display("FAIL fib_period: got %0d expected 255", first_ret); end
        checks++; if (cnt1 !== 32'd255) begin errors++; $display("FAIL fib_cnt: got %0d expected 255", cnt1); end
        out_ready1 = 1'b0;
    endtask

    task automatic test_out_w4_hold();
        out_ready4 = 1'b0;
        do_seed(8'h01);
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_data4 !== 4'h8) begin errors++; $display("FAIL w4_hold_data[%0d]: got %0h expected 8", i, out_data4); end
            checks++; if (cnt4 !== 32'd0) begin errors++; $display("FAIL w4_hold_cnt[%0d]: got %0d expected 0", i, cnt4); end
            checks++; if (state4 !== 8'h01) begin errors++; $display("FAIL w4_hold_state[%0d]: got %0h expected 01", i, state4); end
            tick();
        end
        out_ready4 = 1'b1;
        tick();
        out_ready4 = 1'b0;
        checks++; if (state4 !== 8'h11) begin errors++; $display("FAIL w4_next_state: got %0h expected 11", state4); end
        checks++; if (cnt4 !== 32'd1) begin errors++; $display("FAIL w4_cnt: got %0d expected 1", cnt4); end
    endtask

    task automatic test_galois();
        int n;
        int first_ret;
        do_reset();
        cfg_we   = 1'b1;
        cfg_taps = 8'h1D;
        cfg_mode = 1'b1;
        tick();
        cfg_we = 1'b0;
        do_seed(8'h80);
        checks++; if (out_data1[0] !== 1'b1) begin errors++; $display("FAIL gal_data: got %0b expected 1", out_data1[0]); end
        out_ready1 = 1'b1;
        tick();
        checks++; if (state1 !== 8'h1D) begin errors++; $display("FAIL gal_state: got %0h expected 1d", state1); end
        n = 1;
        first_ret = 0;
        while (n < 255) begin
            tick();
            n++;
            if (state1 == 8'h80 && first_ret == 0) first_ret = n;
        end
        checks++; if (first_ret !== 255) begin errors++; $display("FAIL gal_period: got %0d expected 255", first_ret); end
        out_ready1 = 1'b0;
    endtask

    task automatic test_lockup();
        do_reset();
        cfg_we   = 1'b1;
        cfg_taps = 8'h01;
        cfg_mode = 1'b0;
        do_seed(8'h80);
        cfg_we = 1'b0;
        checks++; if (out_valid1 !== 1'b1) begin errors++; $display("FAIL lock_pre_valid: got %0b expected 1", out_valid1); end
        out_ready1 = 1'b1;
        tick();
        out_ready1 = 1'b0;
        checks++; if (state1 !== 8'h00) begin errors++; $display("FAIL lock_state: got %0h expected 00", state1); end
        checks++; if (lockup1 !== 1'b1) begin errors++; $display("FAIL lock_flag: got %0b expected 1", lockup1); end
        checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL lock_valid: got %0b expected 0", out_valid1); end
        do_seed(8'h05);
        checks++; if (lockup1 !== 1'b0) begin errors++; $display("FAIL relock_flag: got %0b expected 0", lockup1); end
        checks++; if (out_valid1 !== 1'b1) begin errors++; $display("FAIL relock_valid: got %0b expected 1", out_valid1); end
        checks++; if (state1 !== 8'h05) begin errors++; $display("FAIL relock_state: got %0h expected 05", state1); end
        checks++; if (cnt1 !== 32'd0) begin errors++; $display("FAIL relock_cnt: got %0d expected 0", cnt1); end
    endtask

    task automatic test_seed_cfg_in_run();
        do_reset();
        do_seed(8'h00);
        checks++; if (state1 !== 8'h01) begin errors++; $display("FAIL zero_seed_state: got %0h expected 01", state1); end
        checks++; if (out_valid1 !== 1'b1) begin errors++; $display("FAIL zero_seed_valid: got %0b expected 1", out_valid1); end
        cfg_we     = 1'b1;
        cfg_taps   = 8'h01;
        cfg_mode   = 1'b1;
        out_ready1 = 1'b1;
        tick();
        cfg_we = 1'b0;
        tick();
        tick();
        tick();
        checks++; if (state1 !== 8'h11) begin errors++; $display("FAIL run_cfg_ignored: got %0h expected 11", state1); end
        checks++; if (cnt1 !== 32'd4) begin errors++; $display("FAIL run_cnt: got %0d expected 4", cnt1); end
        do_seed(8'h5A);
        checks++; if (state1 !== 8'h5A) begin errors++; $display("FAIL seed_accept_state: got %0h expected 5a", state1); end
        checks++; if (cnt1 !== 32'd0) begin errors++; $display("FAIL seed_accept_cnt: got %0d expected 0", cnt1); end
    endtask

    task automatic test_rst_mid();
        out_ready1 = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        checks++; if (cnt1 !== 32'd10) begin errors++; $display("FAIL mid_cnt: got %0d expected 10", cnt1); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready1 = 1'b0;
        checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %0b expected 0", out_valid1); end
        checks++; if (state1 !== 8'h01) begin errors++; $display("FAIL mid_rst_state: got %0h expected 01", state1); end
        checks++; if (cnt1 !== 32'd0) begin errors++; $display("FAIL mid_rst_cnt: got %0d expected 0", cnt1); end
        checks++; if (lockup1 !== 1'b0) begin errors++; $display("FAIL mid_rst_lockup: got %0b expected 0", lockup1); end
        do_seed(8'h08);
        checks++; if (out_data1[0] !== 1'b1) begin errors++; $display("FAIL mid_rst_taps_data: got %0b expected 1", out_data1[0]); end
        out_ready1 = 1'b1;
        tick();
        out_ready1 = 1'b0;
        checks++; if (state1 !== 8'h11) begin errors++; $display("FAIL mid_rst_taps_state: got %0h expected 11", state1); end
    endtask

    initial begin
        test_reset();
        test_fib_seq();
        test_out_w4_hold();
        test_galois();
        test_lockup();
        test_seed_cfg_in_run();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_stream.md
# lfsr_stream

Parametrised pseudo-random word generator: a W-bit LFSR with a runtime-programmable tap mask, selectable Fibonacci or Galois form, OUT_W bits produced per output word, and valid/ready flow control. The block is the next-generation test-stimulus source for the multiplier datapath. It feeds operand words only when the consumer accepts them. It detects the all-zero lock-up state and counts delivered words.

## Interface
- W, 8, LFSR state width (≥ 3)
- OUT_W, 1, LFSR steps and output bits per word (1 ≤ OUT_W ≤ W)
- DEF_TAPS, 8'hB8, tap mask loaded at reset (x^8+x^6+x^5+x^4+1, maximal for W=8)
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- cfg_we  in  1  write cfg_taps/cfg_mode into config registers
- cfg_taps  in  W  tap mask
- cfg_mode  in  1  0 = Fibonacci, 1 = Galois
- seed_valid  in  1  seed offered
- seed_data  in  W  seed value
- seed_ready  out  1  constant 1; seeds are accepted in every state
- out_valid  out  1  out_data holds a word
- out_ready  in  1  consumer accepts the word
- out_data  out  OUT_W  generated bits; bit 0 is the first step
- state_q  out  W  current LFSR state
- lockup  out  1  state is all-zero
- word_cnt  out  32  words accepted since the last seed; saturates at 2^32-1

## Operation
- Step function, state q, taps t:
  - Fibonacci: fb = ^(q & t); q' = {q[W-2:0], fb}; the step's output bit is fb.
  - Galois: the step's output bit is q[W-1]; q' = {q[W-2:0],1'b0} ^ (q[W-1] ? t : 0).
- out_data is combinational from the registered q, taps and mode.
  - It applies OUT_W steps; bit i is the output bit of step i.
  - q_adv is the state after the OUT_W steps.
- FSM states:
  - IDLE: after reset, out_valid=0.
  - RUN: out_valid=1.
  - LOCK: out_valid=0, lockup=1.
- Transitions:
  - Any state, seed_valid=1: q ← (seed_data==0 ? 1 : seed_data); word_cnt ← 0; next state RUN.
  - RUN, out_valid&&out_ready, no seed: if q_adv==0 then q ← 0 and go to LOCK; otherwise q ← q_adv and word_cnt increments (saturating).
  - LOCK is left only by seeding or rst.
- Simultaneous seed and accept in RUN: the seed wins. The word on out_data that cycle counts as delivered, but word_cnt still becomes 0.
- Config:
  - cfg_we is honoured only in IDLE or LOCK and ignored in RUN.
  - cfg_we together with seed_valid in IDLE/LOCK: both take effect, and the first RUN word uses the new taps and mode.
- Zero seed is replaced by 1. The block never enters RUN with q=0.
- A non-maximal tap mask is legal. Its period is whatever the polynomial gives, and LOCK catches a collapse to zero.

## Timing
- Reset values:
  - q = 1, taps = DEF_TAPS, mode = 0, state IDLE.
  - out_valid = 0, lockup = 0, word_cnt = 0, seed_ready = 1.
- Seed latency: seed accepted at edge k; out_valid=1 and out_data valid in the cycle after edge k.
- Throughput: one word per cycle while out_ready=1. out_data and state_q hold stable while out_valid && !out_ready.
- lockup and out_valid=0 appear in the cycle after the accept that produced the zero state.
- rst mid-RUN: the next cycle shows reset values. Any pending word is discarded and not counted.
- The combinational path is OUT_W chained steps. The implementation unrolls it with a for-loop and adds no registers.

## Test plan
- Reset, then W=8, OUT_W=1, Fibonacci 0xB8, seed 0x01, out_ready=1:
  - out_data sequence starts 0,0,0,1 and state_q goes 01,02,04,08,11.
  - state_q returns to 0x01 exactly after 255 words, and word_cnt=255.
- OUT_W=4, same taps and seed: first word out_data=4'h8, next state_q=0x11. Hold out_ready=0 for 5 cycles: out_data stays 4'h8 and word_cnt does not change.
- Galois mode (cfg_we in IDLE), taps 0x1D, seed 0x80: first out_data bit = 1, then state_q=0x1D. Period is 255.
- Fibonacci taps 0x01, seed 0x80: the first accept leads to q=0x00, lockup=1, out_valid=0. A new seed 0x05 returns to RUN with lockup=0 and word_cnt=0.
- Seed 0x00 gives state_q=0x01 and RUN. cfg_we in RUN leaves the taps unchanged. Seed and accept in the same cycle give the new seed in state_q and word_cnt=0.
- rst asserted mid-stream, for example after 10 words: the next cycle shows IDLE, q=1, out_valid=0, word_cnt=0, and taps back to 0xB8.
